// File: rtl/tile8_board_renderer.sv
// tile8_board_renderer
//   Pixel sequencer and board-state owner for the 8-tile sliding puzzle.
//   It maps VGA pixel coordinates onto a 3x3 board of 128 px cells. Each cell
//   shows a 32x32 region of a 96x96 source image, upscaled by 4. The block
//   drives the external image ROM and a combinational palette, and produces
//   registered RGB with a fixed latency of three cycles. Player moves are
//   accepted with a valid/ready handshake. They are applied only during
//   vertical blank, so a frame never shows a half-updated board.
//
// Ports:
//   clk, reset_n                 pixel clock, synchronous active-low reset
//   draw_x, draw_y, active       pixel being requested this cycle
//   frame_start                  one-cycle pulse at the first vblank cycle
//   rom_addr / rom_index         image ROM address (registered) and its data,
//                                which returns one cycle later
//   pal_index / pal_red..blue    palette lookup (combinational round-trip)
//   red, green, blue             registered pixel colour
//   move_valid, move_dir         move request; dir moves the blank:
//                                0 up, 1 down, 2 left, 3 right
//   move_ready                   request can be accepted this cycle
//   move_done, move_ok           completion pulse and its applied/illegal flag
//   solved                       board is in the solved arrangement
module tile8_board_renderer #(
  parameter int          BOARD_X0 = 128,
  parameter int          BOARD_Y0 = 48,
  parameter int          SRC_W    = 96,
  parameter logic [11:0] BG_RGB   = 12'h222
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  draw_x,
  input  logic [9:0]  draw_y,
  input  logic        active,
  input  logic        frame_start,
  output logic [13:0] rom_addr,
  input  logic [4:0]  rom_index,
  output logic [4:0]  pal_index,
  input  logic [3:0]  pal_red,
  input  logic [3:0]  pal_green,
  input  logic [3:0]  pal_blue,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  input  logic        move_valid,
  input  logic [1:0]  move_dir,
  output logic        move_ready,
  output logic        move_done,
  output logic        move_ok,
  output logic        solved
);

  localparam logic [9:0]  X0 = 10'(BOARD_X0);
  localparam logic [9:0]  X1 = 10'(BOARD_X0 + 384);
  localparam logic [9:0]  Y0 = 10'(BOARD_Y0);
  localparam logic [9:0]  Y1 = 10'(BOARD_Y0 + 384);
  localparam logic [13:0] SW = 14'(SRC_W);
  // Cell i occupies bits [4i+3:4i]; tiles 1..8 in row-major order, blank last.
  localparam logic [35:0] SOLVED = 36'h087654321;

  typedef enum logic [1:0] {IDLE, WAIT_VB, APPLY, DONE} state_t;

  // Read one 4-bit cell from the packed board; out-of-range indices read blank.
  function automatic logic [3:0] f_cell(input logic [35:0] b, input logic [3:0] i);
    return (i <= 4'd8) ? 4'(b >> {i, 2'b00}) : 4'd0;
  endfunction

  // Board state
  logic [35:0] r_board;
  logic [3:0]  r_blank_pos;
  logic        r_solved;
  logic [1:0]  r_dir;
  logic        r_ok;
  logic        r_rdy_en;
  state_t      r_state;
  state_t      w_state_nx;

  // Render pipeline
  logic [13:0] r_rom_addr_p0;
  logic        r_inb_p0, r_blank_p0, r_vld_p0;
  logic        r_inb_p1, r_blank_p1, r_vld_p1;
  logic [11:0] r_rgb_p2;

  // Pixel decode
  logic [8:0]  w_dx, w_dy;
  logic [1:0]  w_col, w_row;
  logic [6:0]  w_lx, w_ly;
  logic [4:0]  w_lx4, w_ly4;
  logic        w_in_board;
  logic [3:0]  w_idx;
  logic [3:0]  w_v;
  logic [1:0]  w_hr, w_hc;
  logic [13:0] w_addr;

  // Offsets are only meaningful inside the board; outside, the in_board flag
  // masks whatever the truncated subtraction produces.
  assign w_dx       = 9'(draw_x - X0);
  assign w_dy       = 9'(draw_y - Y0);
  assign w_col      = w_dx[8:7];
  assign w_row      = w_dy[8:7];
  assign w_lx       = w_dx[6:0];
  assign w_ly       = w_dy[6:0];
  assign w_lx4      = 5'(w_lx >> 2);
  assign w_ly4      = 5'(w_ly >> 2);
  assign w_in_board = (draw_x >= X0) && (draw_x < X1) && (draw_y >= Y0) && (draw_y < Y1);
  assign w_idx      = {2'b00, w_row} * 4'd3 + {2'b00, w_col};
  assign w_v        = f_cell(r_board, w_idx);

  // Home row/column of tile v within the source image.
  always_comb begin
    w_hr = 2'd0;
    w_hc = 2'd0;
    case (w_v)
      4'd1: begin w_hr = 2'd0; w_hc = 2'd0; end
      4'd2: begin w_hr = 2'd0; w_hc = 2'd1; end
      4'd3: begin w_hr = 2'd0; w_hc = 2'd2; end
      4'd4: begin w_hr = 2'd1; w_hc = 2'd0; end
      4'd5: begin w_hr = 2'd1; w_hc = 2'd1; end
      4'd6: begin w_hr = 2'd1; w_hc = 2'd2; end
      4'd7: begin w_hr = 2'd2; w_hc = 2'd0; end
      4'd8: begin w_hr = 2'd2; w_hc = 2'd1; end
      default: ;
    endcase
  end

  // Largest address is 95*96+95 = 9215, so 14-bit arithmetic never wraps.
  assign w_addr = (14'(w_hr) * 14'd32 + 14'(w_ly4)) * SW + 14'(w_hc) * 14'd32 + 14'(w_lx4);

  // ---- Stage 0 -> 1: ROM address and side-band ----
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rom_addr_p0 <= 14'd0;
      r_inb_p0      <= 1'b0;
      r_blank_p0    <= 1'b0;
      r_vld_p0      <= 1'b0;
    end else begin
      r_rom_addr_p0 <= (w_in_board && (w_v != 4'd0)) ? w_addr : 14'd0;
      r_inb_p0      <= w_in_board;
      r_blank_p0    <= (w_v == 4'd0);
      r_vld_p0      <= active;
    end
  end

  // ---- Stage 1 -> 2: side-band waits for the ROM read ----
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_inb_p1   <= 1'b0;
      r_blank_p1 <= 1'b0;
      r_vld_p1   <= 1'b0;
    end else begin
      r_inb_p1   <= r_inb_p0;
      r_blank_p1 <= r_blank_p0;
      r_vld_p1   <= r_vld_p0;
    end
  end

  // ---- Stage 2 -> 3: colour select ----
  always_ff @(posedge clk) begin
    if (!reset_n)       r_rgb_p2 <= 12'h000;
    else if (!r_vld_p1) r_rgb_p2 <= 12'h000;
    else if (!r_inb_p1) r_rgb_p2 <= BG_RGB;
    else if (r_blank_p1) r_rgb_p2 <= 12'h000;
    else                r_rgb_p2 <= {pal_red, pal_green, pal_blue};
  end

  assign rom_addr  = r_rom_addr_p0;
  assign pal_index = rom_index;
  assign {red, green, blue} = r_rgb_p2;
  assign solved    = r_solved;

  // Move legality and neighbour
  logic [1:0]  w_brow, w_bcol;
  logic        w_legal, w_accept;
  logic [3:0]  w_nb, w_nb_val;
  logic [35:0] w_board_nx;

  always_comb begin
    w_brow = 2'd2;
    w_bcol = 2'd2;
    case (r_blank_pos)
      4'd0, 4'd1, 4'd2: w_brow = 2'd0;
      4'd3, 4'd4, 4'd5: w_brow = 2'd1;
      default: ;
    endcase
    case (r_blank_pos)
      4'd0, 4'd3, 4'd6: w_bcol = 2'd0;
      4'd1, 4'd4, 4'd7: w_bcol = 2'd1;
      default: ;
    endcase
  end

  always_comb begin
    w_legal = 1'b0;
    case (move_dir)
      2'd0: w_legal = (w_brow != 2'd0);
      2'd1: w_legal = (w_brow != 2'd2);
      2'd2: w_legal = (w_bcol != 2'd0);
      2'd3: w_legal = (w_bcol != 2'd2);
      default: ;
    endcase
  end

  // The neighbour uses the latched direction; legality was settled at accept.
  always_comb begin
    w_nb = r_blank_pos;
    case (r_dir)
      2'd0: w_nb = r_blank_pos - 4'd3;
      2'd1: w_nb = r_blank_pos + 4'd3;
      2'd2: w_nb = r_blank_pos - 4'd1;
      2'd3: w_nb = r_blank_pos + 4'd1;
      default: ;
    endcase
  end

  assign w_nb_val = f_cell(r_board, w_nb);

  always_comb begin
    w_board_nx = r_board;
    for (int i = 0; i < 9; i++) begin
      if (4'(i) == r_blank_pos)  w_board_nx[4*i +: 4] = w_nb_val;
      else if (4'(i) == w_nb)    w_board_nx[4*i +: 4] = 4'd0;
    end
  end

  assign w_accept = (r_state == IDLE) && r_rdy_en && move_valid;

  // Move FSM: state register
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nx;
  end

  // Move FSM: next state. A frame_start in the accept cycle is not seen
  // because the FSM is still in IDLE then.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nx = w_legal ? WAIT_VB : DONE;
      WAIT_VB: if (frame_start) w_state_nx = APPLY;
      APPLY:   w_state_nx = DONE;
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // Move FSM: outputs
  always_comb begin
    move_ready = 1'b0;
    move_done  = 1'b0;
    move_ok    = 1'b0;
    case (r_state)
      IDLE: move_ready = r_rdy_en;
      DONE: begin
        move_done = 1'b1;
        move_ok   = r_ok;
      end
      default: ;
    endcase
  end

  // Board update happens only in APPLY, which follows frame_start.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_board     <= SOLVED;
      r_blank_pos <= 4'd8;
      r_solved    <= 1'b1;
      r_dir       <= 2'd0;
      r_ok        <= 1'b0;
      r_rdy_en    <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_accept) begin
        r_dir <= move_dir;
        r_ok  <= 1'b0;
      end
      if (r_state == APPLY) begin
        r_board     <= w_board_nx;
        r_blank_pos <= w_nb;
        r_solved    <= (w_board_nx == SOLVED);
        r_ok        <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tile8_board_renderer.sv
module tb_tile8_board_renderer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  draw_x, draw_y;
  logic        active, frame_start;
  logic [13:0] rom_addr;
  logic [4:0]  rom_index;
  logic [4:0]  pal_index;
  logic [3:0]  pal_red, pal_green, pal_blue;
  logic [3:0]  red, green, blue;
  logic        move_valid;
  logic [1:0]  move_dir;
  logic        move_ready, move_done, move_ok, solved;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tile8_board_renderer dut (
    .clk(clk), .reset_n(reset_n),
    .draw_x(draw_x), .draw_y(draw_y), .active(active), .frame_start(frame_start),
    .rom_addr(rom_addr), .rom_index(rom_index), .pal_index(pal_index),
    .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
    .red(red), .green(green), .blue(blue),
    .move_valid(move_valid), .move_dir(move_dir), .move_ready(move_ready),
    .move_done(move_done), .move_ok(move_ok), .solved(solved)
  );

  // Image ROM model: one-cycle read, data = addr[4:0] + 7.
  always @(posedge clk) rom_index <= rom_addr[4:0] + 5'd7;

  // Palette model: index 7 -> CDE, otherwise {idx, ~idx, 5}.
  always_comb begin
    if (pal_index == 5'd7) begin
      pal_red = 4'hC; pal_green = 4'hD; pal_blue = 4'hE;
    end else begin
      pal_red   = pal_index[3:0] ^ {3'b000, pal_index[4]};
      pal_green = ~pal_index[3:0];
      pal_blue  = 4'h5;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_px(input logic [9:0] x, input logic [9:0] y, input logic a);
    draw_x = x; draw_y = y; active = a;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; move_valid = 1'b0; move_dir = 2'd0; frame_start = 1'b0;
    set_px(10'd0, 10'd0, 1'b0);
    repeat (3) tick();
    checks++; if (rom_addr !== 14'd0) begin errors++; $display("FAIL reset_rom_addr got %0d want 0", rom_addr); end
    checks++; if ({red, green, blue} !== 12'h000) begin errors++; $display("FAIL reset_rgb got %h want 000", {red, green, blue}); end
    checks++; if (move_done !== 1'b0 || move_ok !== 1'b0) begin errors++; $display("FAIL reset_done got %b%b want 00", move_done, move_ok); end
    checks++; if (move_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", move_ready); end
    checks++; if (solved !== 1'b1) begin errors++; $display("FAIL reset_solved got %b want 1", solved); end
    reset_n = 1'b1;
    tick();
    checks++; if (move_ready !== 1'b1) begin errors++; $display("FAIL ready_after_release got %b want 1", move_ready); end
  endtask

  task automatic test_first_pixel();
    set_px(10'd128, 10'd48, 1'b1);
    tick();
    checks++; if (rom_addr !== 14'd0) begin errors++; $display("FAIL px0_rom_addr got %0d want 0", rom_addr); end
    tick();
    checks++; if ({red, green, blue} !== 12'h000) begin errors++; $display("FAIL px0_rgb_early got %h want 000", {red, green, blue}); end
    tick();
    checks++; if ({red, green, blue} !== 12'hCDE) begin errors++; $display("FAIL px0_rgb got %h want CDE", {red, green, blue}); end
  endtask

  task automatic test_render();
    set_px(10'd511, 10'd431, 1'b1);
    tick(); tick(); tick();
    checks++; if ({red, green, blue} !== 12'h000) begin errors++; $display("FAIL blank_cell_rgb got %h want 000", {red, green, blue}); end
    set_px(10'd383, 10'd175, 1'b1);
    tick();
    checks++; if (rom_addr !== 14'd3039) begin errors++; $display("FAIL cell1_rom_addr got %0d want 3039", rom_addr); end
    tick(); tick();
    checks++; if ({red, green, blue} !== 12'h695) begin errors++; $display("FAIL cell1_rgb got %h want 695", {red, green, blue}); end
    set_px(10'd10, 10'd10, 1'b1);
    tick(); tick(); tick();
    checks++; if ({red, green, blue} !== 12'h222) begin errors++; $display("FAIL bg_rgb got %h want 222", {red, green, blue}); end
    set_px(10'd200, 10'd100, 1'b0);
    tick(); tick(); tick();
    checks++; if ({red, green, blue} !== 12'h000) begin errors++; $display("FAIL inactive_rgb got %h want 000", {red, green, blue}); end
  endtask

  task automatic test_move_up();
    logic bad;
    move_dir = 2'd0; move_valid = 1'b1;
    checks++; if (move_ready !== 1'b1) begin errors++; $display("FAIL up_ready_idle got %b want 1", move_ready); end
    tick();
    move_valid = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (move_ready !== 1'b0 || move_done !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL up_wait_vb got early ready/done want none"); end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++; if (move_done !== 1'b0) begin errors++; $display("FAIL up_done_early got %b want 0", move_done); end
    tick();
    checks++; if (move_done !== 1'b1 || move_ok !== 1'b1) begin errors++; $display("FAIL up_done got %b%b want 11", move_done, move_ok); end
    checks++; if (move_ready !== 1'b0) begin errors++; $display("FAIL up_ready_in_done got %b want 0", move_ready); end
    tick();
    checks++; if (move_done !== 1'b0 || move_ready !== 1'b1) begin errors++; $display("FAIL up_after_done got done=%b ready=%b want 0 1", move_done, move_ready); end
    checks++; if (solved !== 1'b0) begin errors++; $display("FAIL up_solved got %b want 0", solved); end
    set_px(10'd400, 10'd200, 1'b1);
    tick(); tick(); tick();
    checks++; if ({red, green, blue} !== 12'h000) begin errors++; $display("FAIL up_cell5_rgb got %h want 000", {red, green, blue}); end
    set_px(10'd511, 10'd431, 1'b1);
    tick();
    checks++; if (rom_addr !== 14'd6143) begin errors++; $display("FAIL up_cell8_addr got %0d want 6143", rom_addr); end
    tick(); tick();
    checks++; if ({red, green, blue} !== 12'h695) begin errors++; $display("FAIL up_cell8_rgb got %h want 695", {red, green, blue}); end
  endtask

  task automatic test_illegal();
    int n;
    do_reset();
    move_dir = 2'd1; move_valid = 1'b1;
    tick();
    move_valid = 1'b0;
    n = 0;
    while (move_done !== 1'b1 && n < 4) begin
      tick();
      n++;
    end
    checks++; if (n > 1) begin errors++; $display("FAIL illegal_done_latency got %0d extra cycles want <=1", n); end
    checks++; if (move_ok !== 1'b0) begin errors++; $display("FAIL illegal_ok got %b want 0", move_ok); end
    checks++; if (solved !== 1'b1) begin errors++; $display("FAIL illegal_solved got %b want 1", solved); end
    set_px(10'd511, 10'd431, 1'b1);
    tick();
    checks++; if (rom_addr !== 14'd0) begin errors++; $display("FAIL illegal_cell8_addr got %0d want 0", rom_addr); end
    tick(); tick();
    checks++; if ({red, green, blue} !== 12'h000) begin errors++; $display("FAIL illegal_cell8_rgb got %h want 000", {red, green, blue}); end
  endtask

  task automatic test_back_to_back();
    logic bad;
    // Frame_start coincident with the accept must not trigger the move.
    move_dir = 2'd0; move_valid = 1'b1; frame_start = 1'b1;
    tick();
    move_valid = 1'b0; frame_start = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (move_done !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL b2b_coincident_fs got move_done want none"); end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    checks++; if (move_done !== 1'b1 || move_ok !== 1'b1) begin errors++; $display("FAIL b2b_up_done got %b%b want 11", move_done, move_ok); end
    tick();
    move_dir = 2'd1; move_valid = 1'b1;
    tick();
    move_valid = 1'b0;
    repeat (3) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    checks++; if (move_done !== 1'b1 || move_ok !== 1'b1) begin errors++; $display("FAIL b2b_down_done got %b%b want 11", move_done, move_ok); end
    checks++; if (solved !== 1'b1) begin errors++; $display("FAIL b2b_solved got %b want 1", solved); end
    tick();
    set_px(10'd400, 10'd200, 1'b1);
    tick();
    checks++; if (rom_addr !== 14'd3716) begin errors++; $display("FAIL b2b_cell5_addr got %0d want 3716", rom_addr); end
    tick(); tick();
    checks++; if ({red, green, blue} !== 12'hB45) begin errors++; $display("FAIL b2b_cell5_rgb got %h want B45", {red, green, blue}); end
  endtask

  task automatic test_reset_mid_move();
    logic bad;
    set_px(10'd0, 10'd0, 1'b0);
    move_dir = 2'd0; move_valid = 1'b1;
    tick();
    move_valid = 1'b0;
    tick(); tick();
    reset_n = 1'b0;
    tick();
    checks++; if (move_ready !== 1'b0 || move_done !== 1'b0) begin errors++; $display("FAIL midrst_ctrl got ready=%b done=%b want 0 0", move_ready, move_done); end
    checks++; if (solved !== 1'b1) begin errors++; $display("FAIL midrst_solved got %b want 1", solved); end
    tick();
    reset_n = 1'b1;
    set_px(10'd128, 10'd48, 1'b1);
    tick();
    checks++; if (move_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", move_ready); end
    checks++; if (rom_addr !== 14'd0) begin errors++; $display("FAIL midrst_addr got %0d want 0", rom_addr); end
    tick(); tick();
    checks++; if ({red, green, blue} !== 12'hCDE) begin errors++; $display("FAIL midrst_rgb got %h want CDE", {red, green, blue}); end
    set_px(10'd511, 10'd431, 1'b1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (move_done !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL midrst_stale_done got move_done want none"); end
    checks++; if ({red, green, blue} !== 12'h000) begin errors++; $display("FAIL midrst_cell8_rgb got %h want 000", {red, green, blue}); end
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_render();
    test_move_up();
    test_illegal();
    test_back_to_back();
    test_reset_mid_move();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1);
  end

endmodule
